write_data_route_queue: RTL and testbench

//  Write-data router; sits directly downstream of the write-address decoder.

---
 rtl/write_data_route_queue_pkg.sv | 21 ++
 rtl/write_data_route_queue_route_fifo.sv | 42 ++++
 rtl/write_data_route_queue.sv | 89 ++++++++
 tb/tb_write_data_route_queue.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/write_data_route_queue_pkg.sv
// write_data_route_queue_pkg: shared queue-entry layout and slave-select helpers
package write_data_route_queue_pkg;
  localparam int SLAVES_NUM     = 2;
  localparam int SLAVES_ID_SIZE = $clog2(SLAVES_NUM);
  localparam int AW_LEN_W       = 8;
  localparam int ENTRY_W        = SLAVES_ID_SIZE + AW_LEN_W;
  typedef struct packed {
    logic [SLAVES_ID_SIZE-1:0] slave_idx;
    logic [AW_LEN_W-1:0]       awlen;
  } q_entry_t;
  function automatic logic is_onehot(input logic [SLAVES_NUM-1:0] oh);
    return (oh != '0) && ((oh & (oh - SLAVES_NUM'(1))) == '0);
  endfunction
  function automatic logic [SLAVES_ID_SIZE-1:0] onehot_to_idx(input logic [SLAVES_NUM-1:0] oh);
    logic [SLAVES_ID_SIZE-1:0] idx;
    idx = '0;
    for (int i = 0; i < SLAVES_NUM; i++)
      if (oh[i]) idx = idx | SLAVES_ID_SIZE'(i);
    return idx;
  endfunction
endpackage

// File: rtl/write_data_route_queue_route_fifo.sv
// route_fifo: circular buffer, registered write, combinational head read, count/full/empty
module route_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q;
  assign count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  // Storage has no reset; only entries between rd and wr are ever observed.
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i) rd_q <= rd_q + AW'(1);
      count_q <= count_d;
      full_q  <= count_d == (AW+1)'(DEPTH);
    end
  assign dout_o  = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = count_q == '0;
  assign count_o = count_q;
endmodule

// File: rtl/write_data_route_queue.sv
// write_data_route_queue: steers master W beats to the slave recorded by each accepted AW, in order
module write_data_route_queue
  import write_data_route_queue_pkg::*;
#(
  parameter int Data_Width  = 32,
  parameter int Queue_Depth = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [SLAVES_NUM-1:0]   Q_Enables,
  input  logic [AW_LEN_W-1:0]     Master_AXI_awlen,
  input  logic                    AW_Push,
  output logic                    AW_Queue_Full,
  input  logic [Data_Width-1:0]   Master_AXI_wdata,
  input  logic [Data_Width/8-1:0] Master_AXI_wstrb,
  input  logic                    Master_AXI_wlast,
  input  logic                    Master_AXI_wvalid,
  output logic                    Master_AXI_wready,
  output logic [Data_Width-1:0]   M00_AXI_wdata,
  output logic [Data_Width/8-1:0] M00_AXI_wstrb,
  output logic                    M00_AXI_wlast,
  output logic                    M00_AXI_wvalid,
  input  logic                    M00_AXI_wready,
  output logic [Data_Width-1:0]   M01_AXI_wdata,
  output logic [Data_Width/8-1:0] M01_AXI_wstrb,
  output logic                    M01_AXI_wlast,
  output logic                    M01_AXI_wvalid,
  input  logic                    M01_AXI_wready,
  output logic                    Err_Wlast,
  output logic                    Err_Push
);
  logic [ENTRY_W-1:0]           head_raw;
  q_entry_t                     head, push_entry;
  logic [$clog2(Queue_Depth):0] fifo_count;
  logic                         fifo_empty, fifo_full;
  logic                         push_ok, fire, pop, sel0, sel1;
  logic [AW_LEN_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic                         err_wlast_q, err_wlast_d, err_push_q, err_push_d;
  assign push_entry = '{slave_idx: onehot_to_idx(Q_Enables), awlen: Master_AXI_awlen};
  assign push_ok    = AW_Push && !fifo_full && is_onehot(Q_Enables);
  route_fifo #(.W(ENTRY_W), .DEPTH(Queue_Depth)) u_fifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .push_i  (push_ok),
    .pop_i   (pop),
    .din_i   (push_entry),
    .dout_o  (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );
  assign head          = q_entry_t'(head_raw);
  assign AW_Queue_Full = fifo_full;
  // Steering mux: head entry selects the slave; everything is dark while the queue is empty.
  always_comb begin
    sel0              = !fifo_empty && head.slave_idx == SLAVES_ID_SIZE'(0);
    sel1              = !fifo_empty && head.slave_idx == SLAVES_ID_SIZE'(1);
    M00_AXI_wvalid    = sel0 && Master_AXI_wvalid;
    M00_AXI_wdata     = sel0 ? Master_AXI_wdata : '0;
    M00_AXI_wstrb     = sel0 ? Master_AXI_wstrb : '0;
    M00_AXI_wlast     = sel0 && Master_AXI_wlast;
    M01_AXI_wvalid    = sel1 && Master_AXI_wvalid;
    M01_AXI_wdata     = sel1 ? Master_AXI_wdata : '0;
    M01_AXI_wstrb     = sel1 ? Master_AXI_wstrb : '0;
    M01_AXI_wlast     = sel1 && Master_AXI_wlast;
    Master_AXI_wready = sel0 ? M00_AXI_wready : sel1 ? M01_AXI_wready : 1'b0;
  end
  // Beat tracking and sticky errors; WLAST alone pops, awlen only feeds the check.
  always_comb begin
    fire        = Master_AXI_wvalid && Master_AXI_wready;
    pop         = fire && Master_AXI_wlast;
    beat_cnt_d  = pop ? '0 : fire ? beat_cnt_q + AW_LEN_W'(1) : beat_cnt_q;
    err_wlast_d = err_wlast_q || (fire && (Master_AXI_wlast != (beat_cnt_q == head.awlen)));
    err_push_d  = err_push_q || (AW_Push && (fifo_full || !is_onehot(Q_Enables)));
  end
  // Beat counter and error flag registers.
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      beat_cnt_q  <= '0;
      err_wlast_q <= 1'b0;
      err_push_q  <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      err_wlast_q <= err_wlast_d;
      err_push_q  <= err_push_d;
    end
  assign Err_Wlast = err_wlast_q;
  assign Err_Push  = err_push_q;
endmodule

// File: tb/tb_write_data_route_queue.sv
// tb_write_data_route_queue: directed vectors with hand-computed expectations
module tb_write_data_route_queue;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [1:0]  Q_Enables;
  logic [7:0]  Master_AXI_awlen;
  logic        AW_Push;
  logic        AW_Queue_Full;
  logic [31:0] Master_AXI_wdata;
  logic [3:0]  Master_AXI_wstrb;
  logic        Master_AXI_wlast, Master_AXI_wvalid, Master_AXI_wready;
  logic [31:0] M00_AXI_wdata, M01_AXI_wdata;
  logic [3:0]  M00_AXI_wstrb, M01_AXI_wstrb;
  logic        M00_AXI_wlast, M00_AXI_wvalid, M00_AXI_wready;
  logic        M01_AXI_wlast, M01_AXI_wvalid, M01_AXI_wready;
  logic        Err_Wlast, Err_Push;
  int          n_vec = 0;
  int          n_bad = 0;
  write_data_route_queue dut (
    .ACLK(ACLK), .ARESET(ARESET), .Q_Enables(Q_Enables), .Master_AXI_awlen(Master_AXI_awlen),
    .AW_Push(AW_Push), .AW_Queue_Full(AW_Queue_Full),
    .Master_AXI_wdata(Master_AXI_wdata), .Master_AXI_wstrb(Master_AXI_wstrb),
    .Master_AXI_wlast(Master_AXI_wlast), .Master_AXI_wvalid(Master_AXI_wvalid),
    .Master_AXI_wready(Master_AXI_wready),
    .M00_AXI_wdata(M00_AXI_wdata), .M00_AXI_wstrb(M00_AXI_wstrb), .M00_AXI_wlast(M00_AXI_wlast),
    .M00_AXI_wvalid(M00_AXI_wvalid), .M00_AXI_wready(M00_AXI_wready),
    .M01_AXI_wdata(M01_AXI_wdata), .M01_AXI_wstrb(M01_AXI_wstrb), .M01_AXI_wlast(M01_AXI_wlast),
    .M01_AXI_wvalid(M01_AXI_wvalid), .M01_AXI_wready(M01_AXI_wready),
    .Err_Wlast(Err_Wlast), .Err_Push(Err_Push)
  );
  always #5 ACLK = ~ACLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask
  task automatic push(input logic [1:0] q, input logic [7:0] len);
    Q_Enables = q;
    Master_AXI_awlen = len;
    AW_Push = 1'b1;
    tick();
    AW_Push = 1'b0;
  endtask
  task automatic beat(input int slv, input logic [31:0] data, input logic last);
    Master_AXI_wvalid = 1'b1;
    Master_AXI_wdata = data;
    Master_AXI_wstrb = 4'hA;
    Master_AXI_wlast = last;
    #1;
    chk("m00_wvalid", M00_AXI_wvalid, slv == 0);
    chk("m01_wvalid", M01_AXI_wvalid, slv == 1);
    chk("m_wready", Master_AXI_wready, 1);
    chk("sel_wdata", slv == 0 ? M00_AXI_wdata : M01_AXI_wdata, data);
    chk("unsel_wdata", slv == 0 ? M01_AXI_wdata : M00_AXI_wdata, 0);
    chk("sel_wlast", slv == 0 ? M00_AXI_wlast : M01_AXI_wlast, last);
    tick();
    Master_AXI_wvalid = 1'b0;
    Master_AXI_wlast = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    ARESET = 1'b1;
    Q_Enables = 2'b00;
    Master_AXI_awlen = 8'd0;
    AW_Push = 1'b0;
    Master_AXI_wdata = 32'h0;
    Master_AXI_wstrb = 4'h0;
    Master_AXI_wlast = 1'b0;
    Master_AXI_wvalid = 1'b1;
    M00_AXI_wready = 1'b1;
    M01_AXI_wready = 1'b1;
    tick();
    tick();
    chk("rst_full", AW_Queue_Full, 0);
    chk("rst_wready", Master_AXI_wready, 0);
    chk("rst_m00_wvalid", M00_AXI_wvalid, 0);
    chk("rst_m01_wvalid", M01_AXI_wvalid, 0);
    chk("rst_err_wlast", Err_Wlast, 0);
    chk("rst_err_push", Err_Push, 0);
    ARESET = 1'b0;
    tick();
    Q_Enables = 2'b01;
    Master_AXI_awlen = 8'd3;
    AW_Push = 1'b1;
    #1;
    chk("no_bypass_wready", Master_AXI_wready, 0);
    chk("no_bypass_m00", M00_AXI_wvalid, 0);
    tick();
    AW_Push = 1'b0;
    Master_AXI_wvalid = 1'b0;
    beat(0, 32'h1111_0000, 1'b0);
    beat(0, 32'h1111_0001, 1'b0);
    beat(0, 32'h1111_0002, 1'b0);
    chk("burst_beat_cnt", dut.beat_cnt_q, 3);
    beat(0, 32'h1111_0003, 1'b1);
    chk("burst_popped", dut.fifo_count, 0);
    chk("burst_err_wlast", Err_Wlast, 0);
    chk("burst_beat_cnt_clr", dut.beat_cnt_q, 0);
    Master_AXI_wvalid = 1'b1;
    #1;
    chk("empty_stall", Master_AXI_wready, 0);
    Master_AXI_wvalid = 1'b0;
    push(2'b10, 8'd0);
    push(2'b01, 8'd1);
    push(2'b10, 8'd0);
    chk("order_count", dut.fifo_count, 3);
    beat(1, 32'h2222_0000, 1'b1);
    beat(0, 32'h2222_0001, 1'b0);
    beat(0, 32'h2222_0002, 1'b1);
    beat(1, 32'h2222_0003, 1'b1);
    chk("order_empty", dut.fifo_count, 0);
    chk("order_err_wlast", Err_Wlast, 0);
    for (int i = 0; i < 4; i++) push(2'b01, 8'd0);
    chk("full_set", AW_Queue_Full, 1);
    chk("full_no_err", Err_Push, 0);
    push(2'b01, 8'd0);
    chk("overflow_err_push", Err_Push, 1);
    chk("overflow_count", dut.fifo_count, 4);
    for (int i = 0; i < 4; i++) beat(0, 32'h3333_0000 + i, 1'b1);
    chk("drain_full_clr", AW_Queue_Full, 0);
    chk("drain_count", dut.fifo_count, 0);
    push(2'b10, 8'd1);
    M01_AXI_wready = 1'b0;
    Master_AXI_wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_wready", Master_AXI_wready, 0);
      chk("stall_m01_wvalid", M01_AXI_wvalid, 1);
      tick();
      chk("stall_beat_cnt", dut.beat_cnt_q, 0);
      chk("stall_count", dut.fifo_count, 1);
    end
    M01_AXI_wready = 1'b1;
    beat(1, 32'h4444_0000, 1'b0);
    chk("stall_resume_cnt", dut.beat_cnt_q, 1);
    beat(1, 32'h4444_0001, 1'b1);
    chk("stall_done", dut.fifo_count, 0);
    push(2'b01, 8'd0);
    push(2'b01, 8'd0);
    Q_Enables = 2'b01;
    Master_AXI_awlen = 8'd0;
    AW_Push = 1'b1;
    beat(0, 32'h5555_0000, 1'b1);
    AW_Push = 1'b0;
    chk("pushpop_count", dut.fifo_count, 2);
    beat(0, 32'h5555_0001, 1'b1);
    beat(0, 32'h5555_0002, 1'b1);
    chk("pushpop_drained", dut.fifo_count, 0);
    chk("pre_early_err", Err_Wlast, 0);
    push(2'b01, 8'd3);
    beat(0, 32'h6666_0000, 1'b0);
    beat(0, 32'h6666_0001, 1'b1);
    chk("early_err_wlast", Err_Wlast, 1);
    chk("early_popped", dut.fifo_count, 0);
    push(2'b10, 8'd3);
    beat(1, 32'h7777_0000, 1'b0);
    Master_AXI_wvalid = 1'b1;
    #1;
    chk("midburst_wready", Master_AXI_wready, 1);
    ARESET = 1'b1;
    #1;
    chk("arst_m01_wvalid", M01_AXI_wvalid, 0);
    chk("arst_wready", Master_AXI_wready, 0);
    chk("arst_count", dut.fifo_count, 0);
    chk("arst_beat_cnt", dut.beat_cnt_q, 0);
    chk("arst_err_wlast", Err_Wlast, 0);
    chk("arst_err_push", Err_Push, 0);
    tick();
    ARESET = 1'b0;
    tick();
    chk("post_rst_stall", Master_AXI_wready, 0);
    Master_AXI_wvalid = 1'b0;
    push(2'b11, 8'd0);
    chk("multihot_err_push", Err_Push, 1);
    chk("multihot_dropped", dut.fifo_count, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
